// File: rtl/seven_seg_mux_driver.sv
// Time-multiplexed hex seven-segment driver for N common-anode digits.
// Values are double-buffered and swapped only at frame wrap so a frame never mixes old and new digits.
module seven_seg_mux_driver #(
  parameter int unsigned N_DIGITS      = 8,
  parameter int unsigned REFRESH_DIV   = 100000,
  parameter int unsigned BLANK_LEADING = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   value_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  output logic [6:0]              segments,
  output logic                    dp,
  output logic [N_DIGITS-1:0]     anodes,
  output logic                    frame_done
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam int unsigned IW = $clog2(N_DIGITS);
  localparam int unsigned VW = 4 * N_DIGITS;

  localparam logic [PW-1:0] PCNT_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);
  localparam logic [6:0]    SEG_BLANK = 7'b1111111;

  logic [PW-1:0]       pcnt;
  logic [IW-1:0]       idx;
  logic [VW-1:0]       sh_val;
  logic [N_DIGITS-1:0] sh_dp;
  logic [VW-1:0]       disp_val;
  logic [N_DIGITS-1:0] disp_dp;
  logic                wrap_q;

  logic                tick_c;
  logic                wrap_c;
  logic [N_DIGITS-1:0] lead_zero_c;
  logic [3:0]          nib_c;
  logic                dp_sel_c;
  logic                blank_c;
  logic [N_DIGITS-1:0] an_c;
  logic [6:0]          seg_c;

  // Hex nibble to active-low {a,b,c,d,e,f,g}
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  always_comb begin
    tick_c = enable && (pcnt == PCNT_LAST);
    wrap_c = tick_c && (idx == IDX_LAST);
  end

  // Digit k is a leading zero when it and every digit above it are zero; digit 0 is never blanked
  always_comb begin
    logic upper_zero;
    upper_zero  = 1'b1;
    lead_zero_c = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      upper_zero     = upper_zero && (disp_val[4*k +: 4] == 4'h0);
      lead_zero_c[k] = upper_zero && (k != 0) && (BLANK_LEADING != 0);
    end
  end

  always_comb begin
    nib_c    = 4'h0;
    dp_sel_c = 1'b0;
    blank_c  = 1'b0;
    an_c     = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        nib_c    = disp_val[4*k +: 4];
        dp_sel_c = disp_dp[k];
        blank_c  = lead_zero_c[k];
        an_c[k]  = 1'b0;
      end
    end
    seg_c = blank_c ? SEG_BLANK : seg_decode(nib_c);
  end

  // Scan prescaler and digit index; both freeze while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (enable) begin
      if (tick_c) begin
        pcnt <= '0;
        idx  <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
        pcnt <= pcnt + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_val <= '0;
      sh_dp  <= '0;
    end else if (load) begin
      sh_val <= value_in;
      sh_dp  <= dp_in;
    end
  end

  // Display buffer swaps only at frame wrap; a load in the wrap cycle bypasses the shadow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_val <= '0;
      disp_dp  <= '0;
    end else if (wrap_c) begin
      disp_val <= load ? value_in : sh_val;
      disp_dp  <= load ? dp_in    : sh_dp;
    end
  end

  // frame_done is delayed one stage so it lines up with digit 0 reappearing on the pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      wrap_q     <= wrap_c;
      frame_done <= wrap_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anodes   <= '1;
      segments <= SEG_BLANK;
      dp       <= 1'b1;
    end else if (enable) begin
      anodes   <= an_c;
      segments <= seg_c;
      dp       <= ~dp_sel_c;
    end else begin
      anodes   <= '1;
      segments <= SEG_BLANK;
      dp       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seven_seg_mux_driver.sv
// Scoreboard bench for seven_seg_mux_driver: a position-based display model predicts the pins
// one cycle after each edge; two instances cover leading-zero blanking on and off.
`timescale 1ns/1ps
module tb_seven_seg_mux_driver;

  localparam int unsigned N     = 4;
  localparam int unsigned R     = 4;
  localparam int unsigned FRAME = N * R;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic [6:0] seg_nb;
    logic       dp;
    logic       fd;
  } exp_t;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        enable   = 1'b0;
  logic        load     = 1'b0;
  logic [15:0] value_in = 16'h0;
  logic [3:0]  dp_in    = 4'h0;

  logic [6:0] segments, seg_nb;
  logic       dp, dp_nb;
  logic [3:0] anodes, an_nb;
  logic       frame_done, fd_nb;

  always #5 clk = ~clk;

  seven_seg_mux_driver #(.N_DIGITS(N), .REFRESH_DIV(R), .BLANK_LEADING(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value_in(value_in), .dp_in(dp_in),
    .segments(segments), .dp(dp), .anodes(anodes), .frame_done(frame_done)
  );

  seven_seg_mux_driver #(.N_DIGITS(N), .REFRESH_DIV(R), .BLANK_LEADING(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value_in(value_in), .dp_in(dp_in),
    .segments(seg_nb), .dp(dp_nb), .anodes(an_nb), .frame_done(fd_nb)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  int unsigned m_pos;
  logic [15:0] m_sh_val, m_disp_val;
  logic [3:0]  m_sh_dp, m_disp_dp;
  logic        m_fd_pending;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  task automatic model_reset();
    m_pos        = 0;
    m_sh_val     = 16'h0;
    m_sh_dp      = 4'h0;
    m_disp_val   = 16'h0;
    m_disp_dp    = 4'h0;
    m_fd_pending = 1'b0;
    sb.delete();
  endtask

  // Predict the pins after this edge from the frame position, then advance the model
  task automatic model_edge();
    exp_t        e;
    int unsigned dig;
    logic [15:0] upper;
    logic [3:0]  nib;
    logic        lead;
    dig   = m_pos / R;
    upper = m_disp_val >> (4 * dig);
    nib   = upper[3:0];
    lead  = (dig != 0) && (upper == 16'h0);
    e.an     = enable ? ~(4'b0001 << dig) : 4'hF;
    e.seg    = (!enable || lead) ? 7'h7F : seg_of(nib);
    e.seg_nb = !enable ? 7'h7F : seg_of(nib);
    e.dp     = enable ? ~m_disp_dp[dig] : 1'b1;
    e.fd     = m_fd_pending;
    m_fd_pending = 1'b0;
    if (enable) begin
      if (m_pos == FRAME - 1) begin
        m_pos        = 0;
        m_disp_val   = load ? value_in : m_sh_val;
        m_disp_dp    = load ? dp_in : m_sh_dp;
        m_fd_pending = 1'b1;
      end else begin
        m_pos = m_pos + 1;
      end
    end
    if (load) begin
      m_sh_val = value_in;
      m_sh_dp  = dp_in;
    end
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    e = sb.pop_front();
    check("anodes",     32'(anodes),     32'(e.an));
    check("segments",   32'(segments),   32'(e.seg));
    check("dp",         32'(dp),         32'(e.dp));
    check("frame_done", 32'(frame_done), 32'(e.fd));
    check("nb_anodes",  32'(an_nb),      32'(e.an));
    check("nb_segments",32'(seg_nb),     32'(e.seg_nb));
    check("nb_fd",      32'(fd_nb),      32'(e.fd));
  endtask

  // Called at a falling edge: drive inputs, model the rising edge, compare at the next falling edge
  task automatic step(input logic en, input logic ld, input logic [15:0] v, input logic [3:0] d);
    logic modeled;
    enable   = en;
    load     = ld;
    value_in = v;
    dp_in    = d;
    modeled  = 1'b0;
    @(posedge clk);
    if (rst_n) begin
      model_edge();
      modeled = 1'b1;
    end
    @(negedge clk);
    if (modeled) compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0, 4'h0);
  endtask

  task automatic sync_to(input int unsigned pos, input string tag);
    int n;
    n = 0;
    while (m_pos != pos && n < 40) begin
      step(1'b1, 1'b0, 16'h0, 4'h0);
      n++;
    end
    if (m_pos != pos) check(tag, 32'(m_pos), 32'(pos));
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_anodes"},   32'(anodes),     32'hF);
    check({tag, "_segments"}, 32'(segments),   32'h7F);
    check({tag, "_dp"},       32'(dp),         32'h1);
    check({tag, "_fd"},       32'(frame_done), 32'h0);
    check({tag, "_nb_seg"},   32'(seg_nb),     32'h7F);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_pins("rst");
    model_reset();
    rst_n = 1'b1;

    // Free-running scan of an all-zero display
    idle(40);

    // Mid-frame load must not show until the next frame
    sync_to(6, "sync_mid");
    step(1'b1, 1'b1, 16'hA5F0, 4'b0010);
    idle(36);

    // Load in the wrap-tick cycle bypasses the shadow
    sync_to(FRAME - 1, "sync_wrap");
    step(1'b1, 1'b1, 16'h0030, 4'b0000);
    idle(20);

    // Freeze during digit 2, with a shadow load while dark
    sync_to(9, "sync_dig2");
    for (int i = 0; i < 10; i++) begin
      if (i == 4) step(1'b0, 1'b1, 16'h0B07, 4'b0001);
      else        step(1'b0, 1'b0, 16'h0, 4'h0);
    end
    idle(30);

    // Back-to-back loads: the later one wins
    sync_to(3, "sync_b2b");
    step(1'b1, 1'b1, 16'h1234, 4'b1111);
    step(1'b1, 1'b1, 16'h00C0, 4'b0100);
    idle(36);

    // Asynchronous reset mid-digit-3
    sync_to(13, "sync_dig3");
    #2 rst_n = 1'b0;
    #1 check_reset_pins("async_rst");
    model_reset();
    @(negedge clk);
    check_reset_pins("rst_hold");
    rst_n = 1'b1;
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
